pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 16'd1024, consecutive-stall cycle count that trips the watchdog.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stallreq_from_id  input  1  decode stage requests a stall (load-use hazard).
REQ-005 SHALL have port stallreq_from_ex  input  1  execute stage requests a stall (multi-cycle op).
REQ-006 SHALL have port flush_req_i  input  1  exception/flush request from the memory stage.
REQ-007 SHALL have port flush_pc_i  input  32  handler address accompanying flush_req_i.
REQ-008 SHALL have port stall  output  6  per-stage hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
REQ-009 SHALL have port flush  output  1  clear all pipeline registers this cycle.
REQ-010 SHALL have port new_pc  output  32  PC to load when flush=1, else 32'h0.
REQ-011 SHALL have port state_o  output  2  FSM state: 2'b00 RUN, 2'b01 STALL, 2'b10 FLUSH.
REQ-012 SHALL have port stall_cnt_o  output  16  consecutive stalled cycles, saturating.
REQ-013 SHALL have port total_stall_o  output  32  total stalled cycles since reset, wrapping.
REQ-014 SHALL have port wdog_o  output  1  sticky watchdog flag.

Function
REQ-015 SHALL drive stall, flush, new_pc combinationally from current inputs and state (zero latency); priority flush_req_i > stallreq_from_ex > stallreq_from_id.
REQ-016 SHALL, on flush_req_i=1, drive flush=1, new_pc=flush_pc_i, stall=6'b000000, regardless of stall requests.
REQ-017 SHALL, without flush, drive stall=6'b001111 when stallreq_from_ex=1, else 6'b000111 when stallreq_from_id=1, else 6'b000000.
REQ-018 SHALL, while state_o=FLUSH and flush_req_i=0, mask both stall requests (stall=6'b000000, flush=0) for that one shadow cycle.
REQ-019 SHALL register next state: flush_req_i -> FLUSH; else effective stall (stall[0]=1) -> STALL; else -> RUN; FLUSH never persists without a fresh flush_req_i.
REQ-020 SHALL increment stall_cnt_o each cycle stall[0]=1, saturating at 16'hFFFF, and clear it to 0 on any cycle with stall[0]=0 (including flush cycles).
REQ-021 SHALL increment total_stall_o each cycle stall[0]=1, wrapping 32'hFFFFFFFF -> 0.
REQ-022 SHALL treat simultaneous stallreq_from_id and stallreq_from_ex as an EX stall (6'b001111), counted once.
REQ-023 SHALL leave counters unchanged (no increment) in cycles where flush=1.

Reset
REQ-024 SHALL, while rst=0, asynchronously force state_o=RUN, stall_cnt_o=0, total_stall_o=0, wdog_o=0; combinational outputs then follow REQ-015..REQ-018 from RUN.
REQ-025 SHALL, on reset asserted mid-stall or mid-flush, abandon the operation; first cycle after release behaves as RUN.

Configuration
REQ-026 SHALL, with macro PIPELINE_CTRL_WDOG_EN defined, set wdog_o=1 on the edge where stall_cnt_o would reach WDOG_LIMIT, holding it until reset; stall behaviour is unaffected.
REQ-027 SHALL, without PIPELINE_CTRL_WDOG_EN, tie wdog_o to 0 and omit the watchdog logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: stallreq_from_id=1 for 3 cycles -> stall=6'b000111 each cycle, state_o=STALL, stall_cnt_o=3 then 0 after release, total_stall_o=3.
REQ-029 SHALL cover: both requests=1 one cycle -> stall=6'b001111, total_stall_o +1.
REQ-030 SHALL cover: flush_req_i=1, flush_pc_i=32'hBFC00380, stallreq_from_ex=1 -> flush=1, new_pc=32'hBFC00380, stall=0; next cycle stallreq_from_id=1 -> stall=0 (shadow), following cycle stall=6'b000111.
REQ-031 SHALL cover: with PIPELINE_CTRL_WDOG_EN, WDOG_LIMIT=8, stallreq_from_ex held 8 cycles -> wdog_o=1 after 8th edge, stays 1 after request drops; without macro wdog_o=0 throughout.
REQ-032 SHALL cover: rst pulled low during a 5-cycle stall (stall_cnt_o=2) -> stall_cnt_o=0, total_stall_o=0, state_o=RUN immediately, without waiting for clk.
REQ-033 SHALL cover: total_stall_o preloaded via force to 32'hFFFFFFFF, one stall cycle -> 32'h0; stall_cnt_o held at 16'hFFFF under continued stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation, stall counters, watchdog.
// Optional watchdog enabled by defining PIPELINE_CTRL_WDOG_EN.
module pipeline_ctrl #(
    parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        flush_req_i,
    input  logic [31:0] flush_pc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [31:0] total_stall_o,
    output logic        wdog_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_next;
    logic [31:0] total_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        if (flush_req_i) begin
            state_d = FLUSH;
        end else if (stall[0]) begin
            state_d = STALL;
        end
    end

    // The cycle after a flush is a shadow cycle: stale stall requests are ignored.
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (flush_req_i) begin
            flush  = 1'b1;
            new_pc = flush_pc_i;
        end else if (state_q != FLUSH) begin
            if (stallreq_from_ex) begin
                stall = 6'b001111;
            end else if (stallreq_from_id) begin
                stall = 6'b000111;
            end
        end
    end

    assign stall_cnt_next = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            total_q     <= '0;
        end else if (stall[0]) begin
            stall_cnt_q <= stall_cnt_next;
            total_q     <= total_q + 32'd1;
        end else begin
            stall_cnt_q <= '0;
        end
    end

`ifdef PIPELINE_CTRL_WDOG_EN
    logic wdog_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= 1'b0;
        end else if (stall[0] && (stall_cnt_next == WDOG_LIMIT)) begin
            wdog_q <= 1'b1;
        end
    end

    assign wdog_o = wdog_q;
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_o            = 1'b0;
`endif

    assign state_o       = state_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign total_stall_o = total_q;

endmodule
